// File: rtl/out_wrr_scheduler.sv
// Packet-granular weighted round-robin owner of the egress port; registered one-hot grant one cycle after request.
// Grant is held until pkt_done, with one idle bubble per packet. Per-queue saturating packet counters are read via cnt_sel.
module out_wrr_scheduler #(
  parameter int C_NUM_QUEUES       = 4,
  parameter int C_NUM_QUEUES_WIDTH = 2,
  parameter int C_WEIGHT_WIDTH     = 4,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                                     axis_clk,
  input  logic                                     reset,
  input  logic [C_NUM_QUEUES*C_WEIGHT_WIDTH-1:0]   weights,
  input  logic [C_NUM_QUEUES-1:0]                  req,
  input  logic                                     pkt_done,
  output logic [C_NUM_QUEUES-1:0]                  grant,
  output logic [C_NUM_QUEUES_WIDTH-1:0]            grant_idx,
  output logic                                     grant_valid,
  input  logic                                     clr_cnt,
  input  logic [C_NUM_QUEUES_WIDTH-1:0]            cnt_sel,
  output logic [C_CNT_WIDTH-1:0]                   pkt_cnt
);

  localparam int N  = C_NUM_QUEUES;
  localparam int QW = C_NUM_QUEUES_WIDTH;
  localparam int WW = C_WEIGHT_WIDTH;
  localparam int CW = C_CNT_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [QW-1:0]   ptr, ptr_nxt;
  logic [WW-1:0]   credit, credit_nxt;
  logic [N-1:0]    grant_nxt;
  logic [QW-1:0]   grant_idx_nxt;
  logic            grant_valid_nxt;
  logic            cnt_inc;
  logic [N-1:0]    elig;
  logic [CW-1:0]   cnt [N];

  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] && (weights[i*WW +: WW] != '0);
    end
  end

  always_comb begin
    logic          found;
    logic [QW-1:0] pick;
    logic [QW-1:0] cand;
    state_nxt       = state;
    ptr_nxt         = ptr;
    credit_nxt      = credit;
    grant_nxt       = grant;
    grant_idx_nxt   = grant_idx;
    grant_valid_nxt = grant_valid;
    cnt_inc         = 1'b0;
    found           = 1'b0;
    pick            = ptr;
    cand            = '0;
    unique case (state)
      IDLE: begin
        if (elig[ptr] && credit != '0) begin
          found = 1'b1;
        end else begin
          // Scan starts after ptr and ends on ptr itself, so a lone queue gets reloaded.
          for (int k = 1; k <= N; k++) begin
            cand = QW'((int'(ptr) + k) % N);
            if (!found && elig[cand]) begin
              found      = 1'b1;
              pick       = cand;
              ptr_nxt    = cand;
              credit_nxt = weights[cand*WW +: WW];
            end
          end
        end
        if (found) begin
          state_nxt       = GRANT;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          grant_idx_nxt   = pick;
          grant_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (pkt_done) begin
          credit_nxt      = credit - 1'b1;
          cnt_inc         = 1'b1;
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      credit      <= credit_nxt;
      grant       <= grant_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_valid <= grant_valid_nxt;
    end
  end

  // Clear takes priority over a same-cycle completion.
  always_ff @(posedge axis_clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset || clr_cnt) begin
        cnt[i] <= '0;
      end else if (cnt_inc && ptr == QW'(i) && cnt[i] != '1) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else begin
      pkt_cnt <= cnt[cnt_sel];
    end
  end

endmodule

// File: tb/tb_out_wrr_scheduler.sv
// Directed bench for out_wrr_scheduler: grant order, hold, bubbles, weight gating, counters, reset.
module tb_out_wrr_scheduler;

  localparam int N  = 4;
  localparam int QW = 2;
  localparam int WW = 4;
  localparam int CW = 4;

  logic              axis_clk = 1'b0;
  logic              reset;
  logic [N*WW-1:0]   weights;
  logic [N-1:0]      req;
  logic              pkt_done;
  logic [N-1:0]      grant;
  logic [QW-1:0]     grant_idx;
  logic              grant_valid;
  logic              clr_cnt;
  logic [QW-1:0]     cnt_sel;
  logic [CW-1:0]     pkt_cnt;

  int total = 0;
  int bad   = 0;

  always #5 axis_clk = ~axis_clk;

  out_wrr_scheduler #(
    .C_NUM_QUEUES(N), .C_NUM_QUEUES_WIDTH(QW), .C_WEIGHT_WIDTH(WW), .C_CNT_WIDTH(CW)
  ) dut (
    .axis_clk(axis_clk), .reset(reset), .weights(weights), .req(req),
    .pkt_done(pkt_done), .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .clr_cnt(clr_cnt), .cnt_sel(cnt_sel),
    .pkt_cnt(pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  function automatic logic [N-1:0] onehot(input logic [QW-1:0] q);
    logic [N-1:0] v;
    v = '0;
    v[q] = 1'b1;
    return v;
  endfunction

  // Expects a grant after each step; completes each packet, checks the bubble.
  // seq holds 2-bit queue indices, entry 0 in the low bits. req is cleared after the last packet.
  task automatic run_seq(input string tag, input int n, input logic [63:0] seq);
    logic [QW-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = seq[2*i +: 2];
      step();
      chk({tag, "_gv"}, 32'(grant_valid), 32'd1);
      chk({tag, "_idx"}, 32'(grant_idx), 32'(e));
      chk({tag, "_oh"}, 32'(grant), 32'(onehot(e)));
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0;
      chk({tag, "_bubble"}, 32'(grant_valid), 32'd0);
      chk({tag, "_keepidx"}, 32'(grant_idx), 32'(e));
    end
    req = '0;
    step();
    chk({tag, "_end_idle"}, 32'(grant_valid), 32'd0);
  endtask

  task automatic read_cnt(input string tag, input logic [QW-1:0] sel, input int exp);
    cnt_sel = sel;
    step();
    chk(tag, 32'(pkt_cnt), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; weights = {4'd1, 4'd1, 4'd1, 4'd1}; req = '0;
    pkt_done = 1'b0; clr_cnt = 1'b0; cnt_sel = '0;
    step(); step();
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_gv", 32'(grant_valid), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    end
    chk("rst_idx", 32'(grant_idx), 32'd0);

    // equal weights, all requesting: 1,2,3,0,1
    req = 4'b1111;
    run_seq("rr", 5, {54'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1});
    read_cnt("rr_cnt1", 2'd1, 2);
    read_cnt("rr_cnt0", 2'd0, 1);

    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    read_cnt("clr_cnt1", 2'd1, 0);

    // weighted: q0 gets 3 per turn
    weights = {4'd1, 4'd1, 4'd1, 4'd3};
    req = 4'b0101;
    run_seq("wrr", 8, {48'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2});
    read_cnt("wrr_cnt0", 2'd0, 6);
    read_cnt("wrr_cnt1", 2'd1, 0);
    read_cnt("wrr_cnt2", 2'd2, 2);
    read_cnt("wrr_cnt3", 2'd3, 0);

    // zero weight disables a requesting queue
    weights = {4'd1, 4'd1, 4'd0, 4'd3};
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("w0_gv", 32'(grant_valid), 32'd0);
    end
    weights = {4'd1, 4'd1, 4'd2, 4'd3};
    run_seq("w2", 1, 64'd1);

    // grant held after req drops; ptr=1 credit=1, req[1]=0 so queue 2 wins
    req = 4'b0100;
    step();
    chk("hold_idx", 32'(grant_idx), 32'd2);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_gv", 32'(grant_valid), 32'd1);
      chk("hold_grant", 32'(grant), 32'b0100);
    end
    pkt_done = 1'b1; step(); pkt_done = 1'b0;
    chk("hold_drop", 32'(grant_valid), 32'd0);
    run_seq("hold_next", 1, 64'd0);

    // saturation on q0 with 4-bit counters
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    req = 4'b0001;
    run_seq("sat", 20, 64'd0);
    read_cnt("sat_cnt", 2'd0, 15);

    // clear wins over simultaneous completion
    req = 4'b0001;
    step();
    chk("clr_gv", 32'(grant_valid), 32'd1);
    pkt_done = 1'b1; clr_cnt = 1'b1;
    step();
    pkt_done = 1'b0; clr_cnt = 1'b0; req = '0;
    step();
    chk("clr_win", 32'(pkt_cnt), 32'd0);

    // reset mid-packet
    req = 4'b0001;
    run_seq("pre_rst", 1, 64'd0);
    read_cnt("pre_rst_cnt", 2'd0, 1);
    req = 4'b0001;
    step();
    chk("mid_gv", 32'(grant_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; req = '0;
    chk("mid_rst_gv", 32'(grant_valid), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_idx", 32'(grant_idx), 32'd0);
    read_cnt("mid_rst_cnt", 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_wrr_scheduler.md
# out_wrr_scheduler

Packet-granular weighted round-robin scheduler that decides which of C_NUM_QUEUES egress queues owns the output AXI-Stream port. It sits beside the per-queue output FIFOs: it takes a per-queue "head packet present" request and an end-of-packet strobe from the output handshake, and drives a registered one-hot grant that steers the output mux and FIFO read enables. It also keeps per-queue completed-packet statistics readable through a select port.

## Interface
Parameters:
- C_NUM_QUEUES, 4, number of requesting queues
- C_NUM_QUEUES_WIDTH, 2, width of a queue index
- C_WEIGHT_WIDTH, 4, width of each per-queue weight (packets per turn)
- C_CNT_WIDTH, 32, width of each per-queue packet counter

Ports:
- axis_clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- weights  in  C_NUM_QUEUES*C_WEIGHT_WIDTH  weight of queue i at [i*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH]; 0 = queue disabled
- req  in  C_NUM_QUEUES  queue i has at least one packet head available (FIFO not empty)
- pkt_done  in  1  last beat of granted packet accepted on output (tvalid & tready & tlast)
- grant  out  C_NUM_QUEUES  registered one-hot grant; all-zero when idle
- grant_idx  out  C_NUM_QUEUES_WIDTH  registered index of granted queue
- grant_valid  out  1  registered; high exactly when grant is non-zero
- clr_cnt  in  1  synchronous clear of all packet counters
- cnt_sel  in  C_NUM_QUEUES_WIDTH  counter read select
- pkt_cnt  out  C_CNT_WIDTH  registered value of counter[cnt_sel]

## Operation
- State: IDLE, GRANT. Registers: ptr (current queue), credit (C_WEIGHT_WIDTH bits, packets left in ptr's turn).
- Eligible(i) = req[i] && weights[i] != 0.
- IDLE: if Eligible(ptr) && credit != 0: grant ptr (no reload). Else scan ptr+1, ptr+2, …, wrapping, ending with ptr itself; first eligible q: ptr<=q, credit<=weights[q], grant q. No eligible queue: stay IDLE, outputs zero, ptr/credit unchanged.
- Granting: grant<=onehot(q), grant_idx<=q, grant_valid<=1, state<=GRANT.
- GRANT: hold grant regardless of req (packet committed). On pkt_done: credit<=credit-1, counter[ptr] increments, grant/grant_valid<=0, state<=IDLE. grant_idx retains last value.
- pkt_done in IDLE: ignored (no counter change, no credit change).
- Weights sampled only at credit reload; changes mid-turn affect next reload. Weight of ptr set to 0: current packet completes; ptr ineligible at next IDLE, leftover credit discarded by scan.
- Single active queue: reloaded each time credit exhausts; served back-to-back.
- Counters: saturate at all-ones. clr_cnt zeroes all; clr_cnt with simultaneous pkt_done: result 0 (clear wins).
- pkt_cnt <= counter[cnt_sel] every cycle (pre-update value of the same cycle).

## Timing
- Reset (synchronous, active-high): state=IDLE, ptr=0, credit=0, grant=0, grant_idx=0, grant_valid=0, all counters=0, pkt_cnt=0. Reset mid-packet drops the grant next cycle; no counter update.
- req seen in IDLE at cycle N -> grant_valid high at N+1.
- pkt_done at cycle N -> grant_valid low at N+1; earliest next grant at N+2 (one idle bubble per packet).
- Counter update visible on pkt_cnt two cycles after pkt_done (counter at N+1, read register at N+2).
- Scan is combinational over C_NUM_QUEUES; no multi-cycle search.

## Test plan
- Reset then req=4'b0000 for 10 cycles -> grant_valid=0, grant=0, pkt_cnt=0 throughout.
- weights all 1, req=4'b1111, pkt_done one cycle after each grant -> grant_idx sequence 1,2,3,0,1,… (ptr starts 0, credit 0), one bubble between grants.
- weights={q3:1,q2:1,q1:1,q0:3}, req=4'b0101 -> sequence 2,0,0,0,2,0,0,0; counters after 8 packets: q0=6, q2=2, q1=q3=0.
- weights[1]=0, req=4'b0010 for 20 cycles -> never granted; then weights[1]=2 -> grant to queue 1 next cycle.
- Grant queue 2, drop req[2] mid-packet, raise req[0] -> grant stays on 2 until pkt_done; then grant 0.
- Counter preloaded near all-ones via repeated packets (C_CNT_WIDTH=4 build): 20 pkt_done on q0 -> pkt_cnt=15 saturated; clr_cnt with pkt_done same cycle -> 0; reset asserted mid-packet -> grant_valid=0 next cycle, counters 0.
